// File: rtl/ahb_spi_master.sv
// AHB-Lite slave wrapping a single-byte SPI master (mode 0, MSB first).
// Zero-wait-state register file; SS_N is purely software controlled.
module ahb_spi_master #(
  parameter int unsigned SCK_HALF = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        SPI_SCK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  output logic        SPI_SS_N
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(SCK_HALF - 1);

  state_t      state_r, state_s;
  logic [4:0]  addr_r;
  logic        write_r;
  logic        valid_r;
  logic        ss_r;
  logic [7:0]  tx_r;
  logic [7:0]  rx_r;
  logic [7:0]  shift_r;
  logic        miso_bit_r;
  logic        sck_r;
  logic [7:0]  half_cnt_r;
  logic [3:0]  edge_cnt_r;
  logic        idle_s, shifting_s, done_s, mosi_s;
  logic        wr_start_s, wr_ss_s, wr_data_s;
  logic        half_done_s, last_edge_s;
  logic        unused_s;

  assign unused_s = ^{HSIZE, HADDR[31:5], HWDATA[31:8]};

  assign wr_start_s  = valid_r & write_r & (addr_r == 5'h00) & HWDATA[0];
  assign wr_ss_s     = valid_r & write_r & (addr_r == 5'h04);
  assign wr_data_s   = valid_r & write_r & (addr_r == 5'h12);
  assign half_done_s = (half_cnt_r == HALF_LAST);
  assign last_edge_s = half_done_s & (edge_cnt_r == 4'd15);

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign SPI_SCK   = sck_r;
  assign SPI_SS_N  = ss_r;
  assign SPI_MOSI  = mosi_s;

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; START is only honoured from IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = wr_start_s ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_s = last_edge_s ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // FSM decoded outputs; MOSI shows the held TX MSB while idle
  always_comb begin
    idle_s     = (state_r == ST_IDLE);
    shifting_s = (state_r == ST_SHIFT);
    done_s     = (state_r == ST_DONE);
    if (idle_s) begin
      mosi_s = tx_r[7];
    end else begin
      mosi_s = shift_r[7];
    end
  end

  // AHB address-phase capture and software-visible registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_r  <= 5'd0;
      write_r <= 1'b0;
      valid_r <= 1'b0;
      ss_r    <= 1'b1;
      tx_r    <= 8'h00;
      rx_r    <= 8'h00;
    end else begin
      if (HREADY) begin
        addr_r  <= HADDR[4:0];
        write_r <= HWRITE;
        valid_r <= HSEL & HTRANS[1];
      end
      if (wr_ss_s) begin
        ss_r <= HWDATA[0];
      end
      if (wr_data_s && idle_s) begin
        tx_r <= HWDATA[7:0];
      end
      if (done_s) begin
        rx_r <= shift_r;
      end
    end
  end

  // SCK generator and shifter: sample on rising SCK, shift on falling SCK
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      shift_r    <= 8'h00;
      miso_bit_r <= 1'b0;
      sck_r      <= 1'b0;
      half_cnt_r <= 8'd0;
      edge_cnt_r <= 4'd0;
    end else if (idle_s && wr_start_s) begin
      shift_r    <= tx_r;
      sck_r      <= 1'b0;
      half_cnt_r <= 8'd0;
      edge_cnt_r <= 4'd0;
    end else if (shifting_s) begin
      if (half_done_s) begin
        half_cnt_r <= 8'd0;
        sck_r      <= ~sck_r;
        edge_cnt_r <= edge_cnt_r + 4'd1;
        if (!sck_r) begin
          miso_bit_r <= SPI_MISO;
        end else begin
          shift_r <= {shift_r[6:0], miso_bit_r};
        end
      end else begin
        half_cnt_r <= half_cnt_r + 8'd1;
      end
    end
  end

  // Read mux, driven from the captured address during the data phase
  always_comb begin
    HRDATA = 32'h0000_0000;
    if (valid_r && !write_r) begin
      case (addr_r)
        5'h04:   HRDATA = {31'd0, ss_r};
        5'h08:   HRDATA = {31'd0, idle_s};
        5'h12:   HRDATA = {24'd0, rx_r};
        default: HRDATA = 32'h0000_0000;
      endcase
    end else begin
      HRDATA = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_ahb_spi_master.sv
// Directed testbench for ahb_spi_master: register map, SPI timing/data,
// busy protection, async reset abort and pipelined zero-wait bus behaviour.
module tb_ahb_spi_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        SPI_SCK;
  logic        SPI_MOSI;
  logic        SPI_MISO;
  logic        SPI_SS_N;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          bus_bad = 0;
  int          sck_rises = 0;
  int          sck_falls = 0;
  longint      rise_t [64];
  logic [7:0]  mosi_bits = 8'h00;
  logic        loop_mode = 1'b1;
  logic [7:0]  slave_byte = 8'h00;
  int          fall_base = 0;
  int          slave_idx;

  ahb_spi_master #(.SCK_HALF(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
    .SPI_SS_N(SPI_SS_N)
  );

  always #5 HCLK = ~HCLK;

  // SPI observer: edge times and the MOSI bit seen at every rising SCK
  always @(posedge SPI_SCK) begin
    rise_t[sck_rises % 64] = $time;
    sck_rises = sck_rises + 1;
    mosi_bits = {mosi_bits[6:0], SPI_MOSI};
  end

  always @(negedge SPI_SCK) sck_falls = sck_falls + 1;

  // Mode-0 slave: presents MSB first, advances on each falling SCK
  assign slave_idx = sck_falls - fall_base;
  assign SPI_MISO = loop_mode ? SPI_MOSI :
                    ((slave_idx >= 0 && slave_idx < 8) ? slave_byte[3'(7 - slave_idx)] : 1'b0);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus cycle: new address phase plus data for the previous one
  task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic wr,
                           input logic [4:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = {27'h0200000, addr};
    HWDATA = wdata;
    @(negedge HCLK);
    rdata = HRDATA;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) bus_bad++;
    @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_wr(input logic [4:0] addr, input logic [31:0] data);
    logic [31:0] d;
    bus_cycle(1'b1, 2'b10, 1'b1, addr, 32'h0, d);
    bus_cycle(1'b0, 2'b00, 1'b0, 5'h00, data, d);
  endtask

  task automatic ahb_rd(input logic [4:0] addr, output logic [31:0] data);
    logic [31:0] d;
    bus_cycle(1'b1, 2'b10, 1'b0, addr, 32'h0, d);
    bus_cycle(1'b0, 2'b00, 1'b0, 5'h00, 32'h0, data);
  endtask

  // READY address already issued for cycle k0; returns first cycle reading 1
  task automatic wait_ready(input int k0, output int k_done);
    logic [31:0] r;
    k_done = -1;
    for (int k = k0 + 1; k <= k0 + 300; k++) begin
      bus_cycle(1'b1, 2'b10, 1'b0, 5'h08, 32'h0, r);
      if (r[0]) begin
        k_done = k;
        break;
      end
    end
    bus_cycle(1'b0, 2'b00, 1'b0, 5'h00, 32'h0, r);
  endtask

  task automatic start_and_wait(output int lat);
    logic [31:0] d;
    bus_cycle(1'b1, 2'b10, 1'b1, 5'h00, 32'h0, d);
    bus_cycle(1'b1, 2'b10, 1'b0, 5'h08, 32'h1, d);
    wait_ready(0, lat);
  endtask

  initial begin
    logic [31:0] r;
    int lat, rb;
    bit got_edge;

    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd2; HWDATA = 32'h0; HREADY = 1'b1;
    repeat (10) @(posedge HCLK);
    #1;
    check_val("rst_sck", SPI_SCK, 1'b0);
    check_val("rst_ss_n", SPI_SS_N, 1'b1);
    check_val("rst_mosi", SPI_MOSI, 1'b0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    ahb_rd(5'h04, r); check_val("rst_rd_ss", r, 32'h1);
    ahb_rd(5'h08, r); check_val("rst_rd_ready", r, 32'h1);
    ahb_rd(5'h12, r); check_val("rst_rd_data", r, 32'h0);

    // Loopback 0xAA
    loop_mode = 1'b1;
    ahb_wr(5'h04, 32'h0);
    check_val("ss_low", SPI_SS_N, 1'b0);
    ahb_wr(5'h12, 32'hAA);
    check_val("idle_mosi_aa", SPI_MOSI, 1'b1);
    rb = sck_rises;
    start_and_wait(lat);
    check_val("lb_latency", lat, 32'd66);
    check_val("lb_pulses", sck_rises - rb, 32'd8);
    check_val("lb_period", 32'(rise_t[(rb + 7) % 64] - rise_t[rb % 64]), 32'd560);
    check_val("lb_mosi", mosi_bits, 8'hAA);
    ahb_rd(5'h12, r); check_val("lb_rx", r, 32'hAA);
    check_val("lb_sck_idle", SPI_SCK, 1'b0);

    // Slave returns 0x5C for TX 0x33; DATA/START writes while busy are ignored
    loop_mode = 1'b0;
    slave_byte = 8'h5C;
    fall_base = sck_falls;
    ahb_wr(5'h12, 32'h33);
    rb = sck_rises;
    bus_cycle(1'b1, 2'b10, 1'b1, 5'h00, 32'h0, r);
    bus_cycle(1'b1, 2'b10, 1'b1, 5'h12, 32'h1, r);
    bus_cycle(1'b1, 2'b10, 1'b1, 5'h00, 32'hFF, r);
    bus_cycle(1'b1, 2'b10, 1'b0, 5'h08, 32'h1, r);
    wait_ready(2, lat);
    check_val("busy_latency", lat, 32'd66);
    check_val("busy_pulses", sck_rises - rb, 32'd8);
    check_val("slave_mosi", mosi_bits, 8'h33);
    ahb_rd(5'h12, r); check_val("slave_rx", r, 32'h5C);
    check_val("busy_tx_kept", SPI_MOSI, 1'b0);
    repeat (40) @(posedge HCLK);
    #1;
    check_val("busy_no_second", sck_rises - rb, 32'd8);
    ahb_rd(5'h08, r); check_val("busy_ready_after", r, 32'h1);

    // Pipelined accesses with idle/unselected phases in between
    loop_mode = 1'b1;
    ahb_wr(5'h12, 32'h80);
    check_val("tx80_mosi", SPI_MOSI, 1'b1);
    bus_cycle(1'b1, 2'b10, 1'b1, 5'h04, 32'h0, r);
    bus_cycle(1'b1, 2'b00, 1'b1, 5'h04, 32'h1, r);
    check_val("pipe_ss_set", SPI_SS_N, 1'b1);
    bus_cycle(1'b0, 2'b10, 1'b1, 5'h12, 32'h0, r);
    check_val("pipe_idle_ignored", SPI_SS_N, 1'b1);
    bus_cycle(1'b1, 2'b11, 1'b1, 5'h08, 32'h0, r);
    check_val("pipe_unsel_ignored", SPI_MOSI, 1'b1);
    bus_cycle(1'b1, 2'b10, 1'b1, 5'h04, 32'h0, r);
    bus_cycle(1'b1, 2'b10, 1'b0, 5'h04, 32'h0, r);
    bus_cycle(1'b1, 2'b10, 1'b0, 5'h08, 32'h0, r);
    check_val("pipe_rd_ss", r, 32'h0);
    bus_cycle(1'b1, 2'b10, 1'b0, 5'h00, 32'h0, r);
    check_val("pipe_rd_ready", r, 32'h1);
    bus_cycle(1'b1, 2'b10, 1'b0, 5'h1C, 32'h0, r);
    check_val("pipe_rd_start", r, 32'h0);
    bus_cycle(1'b0, 2'b00, 1'b0, 5'h00, 32'h0, r);
    check_val("pipe_rd_unmapped", r, 32'h0);

    // DATA immediately followed by START uses the new byte
    rb = sck_rises;
    bus_cycle(1'b1, 2'b10, 1'b1, 5'h12, 32'h0, r);
    bus_cycle(1'b1, 2'b10, 1'b1, 5'h00, 32'h96, r);
    bus_cycle(1'b1, 2'b10, 1'b0, 5'h08, 32'h1, r);
    wait_ready(0, lat);
    check_val("b2b_latency", lat, 32'd66);
    check_val("b2b_mosi", mosi_bits, 8'h96);
    ahb_rd(5'h12, r); check_val("b2b_rx", r, 32'h96);

    // Reset at the 7th SCK edge (4th rising edge)
    ahb_wr(5'h12, 32'hAA);
    rb = sck_rises;
    bus_cycle(1'b1, 2'b10, 1'b1, 5'h00, 32'h0, r);
    bus_cycle(1'b0, 2'b00, 1'b0, 5'h00, 32'h1, r);
    got_edge = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sck_rises - rb >= 4) begin
        got_edge = 1'b1;
        break;
      end
      @(posedge HCLK);
    end
    check_val("rst_mid_edge7", got_edge, 1'b1);
    check_val("rst_mid_sck_high", SPI_SCK, 1'b1);
    #2;
    HRESETn = 1'b0;
    #1;
    check_val("rst_mid_sck", SPI_SCK, 1'b0);
    check_val("rst_mid_ss_n", SPI_SS_N, 1'b1);
    check_val("rst_mid_mosi", SPI_MOSI, 1'b0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    ahb_rd(5'h04, r); check_val("rst_mid_rd_ss", r, 32'h1);
    ahb_rd(5'h08, r); check_val("rst_mid_rd_ready", r, 32'h1);
    ahb_rd(5'h12, r); check_val("rst_mid_rd_data", r, 32'h0);
    rb = sck_rises;
    repeat (100) @(posedge HCLK);
    #1;
    check_val("rst_mid_no_resume", sck_rises - rb, 32'd0);

    // Fresh transfer after reset
    ahb_wr(5'h04, 32'h0);
    bus_cycle(1'b1, 2'b10, 1'b1, 5'h12, 32'h0, r);
    bus_cycle(1'b1, 2'b10, 1'b1, 5'h00, 32'h5A, r);
    bus_cycle(1'b1, 2'b10, 1'b0, 5'h08, 32'h1, r);
    wait_ready(0, lat);
    check_val("post_rst_latency", lat, 32'd66);
    ahb_rd(5'h12, r); check_val("post_rst_rx", r, 32'h5A);

    check_val("bus_okay_zero_wait", bus_bad, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ahb_spi_master.md
AHB_SPI_MASTER -- requirements
Module: ahb_spi_master

Interface
REQ-001 SHALL have parameter SCK_HALF, default 4, meaning HCLK cycles per SPI_SCK half-period (legal range 1..255).
REQ-002 SHALL have port HCLK, input, 1, the single clock for all logic.
REQ-003 SHALL have port HRESETn, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port HSEL, input, 1, slave select from the AHB decoder.
REQ-005 SHALL have port HADDR, input, 32, address; only HADDR[4:0] is decoded.
REQ-006 SHALL have port HTRANS, input, 2, transfer type; only NONSEQ/SEQ (HTRANS[1]=1) is active.
REQ-007 SHALL have the following inputs: HWRITE (1), HSIZE (3, ignored), HWDATA (32), and HREADY (1, bus ready).
REQ-008 SHALL have the following outputs: HRDATA (32), HREADYOUT (1), and HRESP (1).
REQ-009 SHALL have the following SPI ports: SPI_SCK (output, 1), SPI_MOSI (output, 1), SPI_MISO (input, 1), and SPI_SS_N (output, 1).

Function
REQ-010 SHALL capture address, write flag and valid flag in the address phase when HSEL & HTRANS[1] & HREADY; the access completes in the following data phase.
REQ-011 SHALL drive HREADYOUT=1 and HRESP=0 at all times, so every access has zero wait states and reports OKAY.
REQ-012 SHALL use this register map on HADDR[4:0]:
- 0x00 START: write-only; HWDATA[0]=1 starts a transfer.
- 0x04 SS: read/write; bit0 drives SPI_SS_N directly.
- 0x08 READY: read-only; bit0=1 means idle.
- 0x12 DATA: write loads TX byte from HWDATA[7:0]; read returns the last RX byte.
REQ-013 SHALL return zeros in the unused HRDATA bits, and return 0 for reads of START or of any unmapped offset; writes to READY or to unmapped offsets SHALL have no effect.
REQ-014 SHALL drive HRDATA combinationally from the captured address during the data phase.
REQ-015 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE.
REQ-016 SHALL move from IDLE to SHIFT on a START write with bit0=1; the shift register loads the TX byte, and READY reads 0 from the cycle after the START data phase.
REQ-017 SHALL run SPI mode 0, MSB first, 8 bits per transfer:
- SPI_SCK idles low.
- SPI_MOSI presents bit7 on SHIFT entry.
- SPI_MISO is sampled on each SCK rising edge.
- SPI_MOSI advances on each SCK falling edge.
REQ-018 SHALL hold each SCK phase for exactly SCK_HALF HCLK cycles, using an 8-bit half-period counter and a 4-bit edge counter (16 edges per transfer).
REQ-019 SHALL, after the 16th edge, enter DONE for 1 cycle, latch the 8 sampled bits into the RX register, and return to IDLE with READY=1; total START-to-READY latency is 16*SCK_HALF+2 HCLK cycles.
REQ-020 SHALL ignore START writes while in SHIFT or DONE.
REQ-021 SHALL ignore DATA writes while busy, leaving the TX byte unchanged.
REQ-022 SHALL NOT modify SPI_SS_N; SS is software-controlled only.
REQ-023 SHALL start a transfer when START and DATA writes arrive back-to-back with DATA first, using the new TX byte.
REQ-024 SHALL drive SPI_MOSI to the held TX bit7 while idle.

Reset
REQ-025 SHALL, while HRESETn=0 and regardless of HCLK, force the following:
- FSM to IDLE, with READY reading 1.
- SPI_SCK=0, SPI_MOSI=0, SPI_SS_N=1.
- TX=0x00, RX=0x00, and counters=0.
- Captured valid flag=0.
REQ-026 SHALL, when reset is asserted mid-transfer, abort immediately with no RX update, and not resume after release.
REQ-027 SHALL accept a new START on the first address/data phase pair after reset release.

Verification
REQ-028 Reset values: assert HRESETn low for 10 cycles, then read SS, READY and DATA -> 1, 1, 0x00; SPI_SCK=0.
REQ-029 Loopback (SPI_MISO tied to SPI_MOSI), SCK_HALF=4: write SS=0, DATA=0xAA, START=1 -> READY=0 for 66 cycles; 8 SCK pulses, 8 cycles each; DATA read=0xAA.
REQ-030 Slave model returning 0x5C while TX=0x33 -> MOSI bit stream 00110011; DATA read=0x5C.
REQ-031 Busy protection: mid-transfer, write DATA=0xFF and START=1 -> current transfer unaffected; TX still the old value; no second transfer.
REQ-032 Reset mid-transfer: pulse HRESETn low at edge 7 -> SCK=0, SS_N=1, READY=1, and DATA read=0x00 after release.
REQ-033 Back-to-back zero-wait accesses, including an IDLE HTRANS and HSEL=0 in between -> only selected NONSEQ phases update registers; HREADYOUT stays 1 throughout.
